// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Stall/flush controller for the 5-stage pipeline. It sits right after the
// hazard detection unit and turns its hazard flags into the enables and
// NOP-insert controls of the front end of the pipe.
//
// Multi-cycle stalls are tracked with a small FSM plus a "remaining cycles"
// counter. In RUN the outputs react combinationally to the hazard inputs so
// the pipe is frozen in the same cycle the hazard is seen. In every other
// state the outputs depend only on the state, so garbage on the hazard inputs
// while stalled or halted cannot disturb the pipe.
//
// A saturating performance counter records every cycle in which the PC was
// held (pc_en low), including the cycles spent in HALT.
//
// Parameters:
//   BR_STALL     total fetch-squash cycles after a branch/jump in ID (1..7)
//   CNT_W        width of the stall-cycle counter
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset, beats every other input
//   data_haz_s1  RAW hazard against the instruction in MEM
//   data_haz_s2  RAW hazard against the instruction in EX
//   branch_haz   branch or jump instruction in ID
//   halt_id      HALT instruction in ID
//   pc_en        PC register write enable
//   if_id_en     IF/ID register write enable
//   if_id_flush  load a NOP into IF/ID this cycle
//   id_ex_bubble load a NOP into ID/EX this cycle
//   pc_load      PC takes the branch target this cycle
//   stalled      FSM is not in RUN
//   halted       FSM is in HALT
//   stall_cnt    number of cycles with pc_en low, saturating at all-ones
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned BR_STALL = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_haz_s1,
    input  logic             data_haz_s2,
    input  logic             branch_haz,
    input  logic             halt_id,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pc_load,
    output logic             stalled,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    // The remaining-cycles counter only has to hold BR_STALL-1 (at most 6)
    // or the single extra data-stall cycle, so three bits are plenty.
    localparam int unsigned REM_W = 3;

    // Number of BSTALL cycles that follow the branch detection cycle.
    localparam logic [REM_W-1:0] BR_REM = REM_W'(BR_STALL - 1);

    // With BR_STALL of 1 the whole squash fits in the detection cycle, so
    // the FSM never leaves RUN for a branch.
    localparam bit BR_SINGLE = (BR_STALL <= 1);

    // An EX-stage producer needs one more cycle beyond the detection cycle.
    localparam logic [REM_W-1:0] DATA_REM = REM_W'(1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        BSTALL = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [REM_W-1:0]  rem_q;
    logic [REM_W-1:0]  rem_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    // Next-state and output decode.
    //
    // Everything starts from the "pipe flowing freely" values, and each state
    // only overrides what it has to. Only the RUN branch looks at the hazard
    // inputs; the other states deliberately ignore them so that the pipe is
    // immune to whatever the detection unit produces while we are stalled.
    //
    // Priority in RUN: EX-stage data hazard, then MEM-stage data hazard, then
    // branch, then HALT. A branch that arrives together with a data hazard is
    // simply held in ID by the data stall and gets handled once we are back
    // in RUN, which is why data hazards win.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pc_load      = 1'b0;

        case (state_q)
            RUN: begin
                if (data_haz_s2) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = DSTALL;
                    rem_d        = DATA_REM;
                end else if (data_haz_s1) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (branch_haz) begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    if (BR_SINGLE) begin
                        pc_load = 1'b1;
                    end else begin
                        state_d = BSTALL;
                        rem_d   = BR_REM;
                    end
                end else if (halt_id) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = HALT;
                end
            end

            DSTALL: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
                if (rem_q <= DATA_REM) begin
                    state_d = RUN;
                    rem_d   = '0;
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end

            BSTALL: begin
                if_id_flush = 1'b1;
                if (rem_q <= REM_W'(1)) begin
                    // Last squash cycle: the PC picks up the target now.
                    pc_load = 1'b1;
                    state_d = RUN;
                    rem_d   = '0;
                end else begin
                    pc_en = 1'b0;
                    rem_d = rem_q - 1'b1;
                end
            end

            HALT: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end

            default: begin
                state_d = RUN;
                rem_d   = '0;
            end
        endcase
    end

    // Status flags come straight from the state register.
    always_comb begin
        stalled = (state_q != RUN);
        halted  = (state_q == HALT);
    end

    // Performance counter: count every cycle the PC is held and stick at the
    // top value instead of wrapping, so a long HALT still reads as "a lot".
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, remaining-cycles and counter registers. Reset is synchronous
    // and overrides everything else, including a pending branch target load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            rem_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
